// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a burst of words from a synchronous RAM and emits them on a valid/ready stream.
// The RAM word is forwarded straight through when the FIFO is empty, so the first word appears two cycles after start.
module ram_stream_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    localparam logic [ADDR_WIDTH:0] ONE = 1;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   issue_left_q, issue_left_d, xfer_left_q, xfer_left_d;
    logic                  inflight_q, inflight_d, done_q, done_d;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic                  rd_q, rd_d, wr_q, wr_d;
    logic [1:0]            count_q, count_d;
    logic                  issue, xfer, push, pop;
    always_comb begin
        m_valid  = count_q != 2'd0 || inflight_q;
        m_data   = count_q != 2'd0 ? mem_q[rd_q] : inflight_q ? ram_dout : '0;
        m_last   = m_valid && xfer_left_q == ONE;
        xfer     = m_valid && m_ready;
        // never have more than two words owed to the consumer once this cycle's transfer is counted
        issue    = state_q == READ && ({1'b0, count_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, xfer});
        pop      = xfer && count_q != 2'd0;
        push     = inflight_q && !(xfer && count_q == 2'd0);
        ram_en   = issue;
        ram_we   = 1'b0;
        ram_addr = addr_q;
        busy     = state_q != IDLE;
        done     = done_q;
        state_d      = state_q;
        addr_d       = issue ? addr_q + 1'b1 : addr_q;
        issue_left_d = issue ? issue_left_q - ONE : issue_left_q;
        xfer_left_d  = xfer ? xfer_left_q - ONE : xfer_left_q;
        inflight_d   = issue;
        done_d       = 1'b0;
        mem_d        = mem_q;
        if (push) mem_d[wr_q] = ram_dout;
        wr_d    = push ? ~wr_q : wr_q;
        rd_d    = pop ? ~rd_q : rd_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (state_q == IDLE && start) begin
            done_d = length == '0;
            if (length != '0) begin
                state_d      = READ;
                addr_d       = base_addr;
                issue_left_d = length;
                xfer_left_d  = length;
            end
        end
        if (state_q == READ && issue && issue_left_q == ONE) state_d = DRAIN;
        if (state_q == DRAIN && xfer && m_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            xfer_left_q  <= '0;
            inflight_q   <= 1'b0;
            done_q       <= 1'b0;
            mem_q        <= '{default: '0};
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            count_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            xfer_left_q  <= xfer_left_d;
            inflight_q   <= inflight_d;
            done_q       <= done_d;
            mem_q        <= mem_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            count_q      <= count_d;
        end
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: burst table plus reset sequence, words and addresses checked against queues filled at start.
module tb_ram_stream_reader;
    localparam int AW = 8;
    localparam int DW = 8;
    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, m_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          ram_en, ram_we, m_valid, m_last, busy, done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout = '0, m_data;
    logic [DW-1:0] ram [256];
    typedef struct packed {logic [DW-1:0] data; logic last;} word_t;
    typedef struct {logic [7:0] base; int len; bit tog; bit restart; int lat;} vec_t;
    word_t         exp_q [$];
    logic [AW-1:0] addr_q [$];
    int            checks = 0, errors = 0, outstanding = 0;
    logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;
    vec_t          vecs [8];

    always #5 clk = ~clk;

    ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always @(posedge clk) if (ram_en) ram_dout <= ram[ram_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        word_t w;
        if (!rst_n) begin
            outstanding = 0;
            pv = 1'b0;
        end else begin
            if (ram_we) chk("ram_we", ram_we, 0);
            if (pv && !pr) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, pd);
                chk("stall_last", m_last, pl);
            end
            if (ram_en) begin
                chk("addr_expected", addr_q.size() != 0, 1);
                if (addr_q.size() != 0) chk("ram_addr", ram_addr, addr_q.pop_front());
                chk("en_pending_lt2", (outstanding - int'(m_valid && m_ready)) < 2, 1);
            end
            if (m_valid && m_ready) begin
                chk("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    chk("m_data", m_data, w.data);
                    chk("m_last", m_last, w.last);
                end
            end
            outstanding += int'(ram_en) - int'(m_valid && m_ready);
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
        end
    end

    task automatic load(input logic [7:0] base, input int len);
        logic [7:0] a;
        for (int i = 0; i < len; i++) begin
            a = base + 8'(i);
            exp_q.push_back('{data: ram[a], last: i == len - 1});
            addr_q.push_back(a);
        end
    endtask

    task automatic run(input logic [7:0] base, input int len, input bit tog, input bit restart, input int exp_lat);
        int k, first;
        bit seen;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; length = (AW+1)'(len); m_ready = 1'b1;
        load(base, len);
        @(posedge clk); #1;
        k = 1; first = 0; seen = 1'b0;
        while (k < 1000 && !seen) begin
            start = restart && k <= 3;
            if (restart) begin base_addr = 8'h90; length = 9'd7; end
            m_ready = tog ? (k % 3 == 2) : 1'b1;
            @(negedge clk);
            if (m_valid && first == 0) first = k;
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                k++;
            end
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        if (exp_lat != 0) chk("done_latency", k, exp_lat);
        chk("first_valid", first, len != 0 ? 2 : 0);
        chk("busy_at_done", busy, 0);
        chk("words_left", exp_q.size(), 0);
        chk("addrs_left", addr_q.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        exp_q.delete();
        addr_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        vecs[0] = '{8'h10, 4, 1'b0, 1'b0, 6};
        vecs[1] = '{8'hFE, 4, 1'b0, 1'b0, 6};
        vecs[2] = '{8'h00, 0, 1'b0, 1'b0, 1};
        vecs[3] = '{8'h20, 5, 1'b1, 1'b0, 15};
        vecs[4] = '{8'h00, 256, 1'b0, 1'b0, 258};
        vecs[5] = '{8'hFF, 1, 1'b0, 1'b0, 3};
        vecs[6] = '{8'h80, 2, 1'b1, 1'b0, 6};
        vecs[7] = '{8'h30, 5, 1'b0, 1'b1, 7};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_m_data", m_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        foreach (vecs[i]) run(vecs[i].base, vecs[i].len, vecs[i].tog, vecs[i].restart, vecs[i].lat);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'h40; length = 9'd8; m_ready = 1'b1;
        load(8'h40, 8);
        repeat (3) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b0; m_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; m_ready = 1'b1;
        chk("pre_reset_words", exp_q.size(), 6);
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_last", m_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ram_en", ram_en, 0);
        chk("mid_rst_ram_addr", ram_addr, 0);
        chk("mid_rst_m_data", m_data, 0);
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_quiet", {m_valid, ram_en, busy, done}, 0);
        end
        run(8'h40, 8, 1'b0, 1'b0, 10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1);
    end
endmodule
